pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC and address width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC target on trap or misaligned redirect.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 stall  input  1  pipeline hold; blocks sequential and RAS advance.
REQ-008 if_ready  input  1  instruction memory accepts current pc_out.
REQ-009 trap_valid  input  1  trap request.
REQ-010 redirect_valid  input  1  resolved branch/jump from execute.
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 ras_push  input  1  call decoded; push ras_push_addr.
REQ-013 ras_push_addr  input  XLEN  return address of the call.
REQ-014 ras_pop  input  1  return decoded; predict target from RAS top.
REQ-015 pc_out  output  XLEN  current fetch PC, registered.
REQ-016 pc_valid  output  1  pc_out is a valid fetch request.
REQ-017 misalign_err  output  1  one-cycle pulse: redirect target not 4-byte aligned.
REQ-018 ras_count  output  $clog2(RAS_DEPTH+1)  occupied RAS entries.
REQ-019 ras_empty  output  1  ras_count == 0.

Function
REQ-020 fire = pc_valid & if_ready & ~stall & ~trap_valid & ~redirect_valid.
REQ-021 Next-PC priority, evaluated each rising edge: trap > redirect > RAS pop > sequential > hold.
REQ-022 trap_valid: pc_out <= TRAP_VECTOR next edge, regardless of stall or if_ready.
REQ-023 redirect_valid (no trap), redirect_pc[1:0]==0: pc_out <= redirect_pc next edge, regardless of stall or if_ready.
REQ-024 redirect_valid (no trap), redirect_pc[1:0]!=0: pc_out <= TRAP_VECTOR, misalign_err = 1 for exactly that following cycle.
REQ-025 fire & ras_pop & ~ras_empty: pc_out <= RAS top entry.
REQ-026 fire otherwise (includes ras_pop with RAS empty): pc_out <= pc_out + 4, modulo 2^XLEN (wraps to 0).
REQ-027 No fire, trap, or redirect: pc_out holds.
REQ-028 pc_valid = 0 in reset; 1 from the first edge after reset release onward.
REQ-029 RAS: circular buffer with a top pointer; push/pop act only on fire.
REQ-030 Push, not full: write entry at top+1, ras_count += 1.
REQ-031 Push, full: overwrite oldest entry (pointer wraps), ras_count stays RAS_DEPTH.
REQ-032 Pop, not empty: ras_count -= 1.
REQ-033 Pop, empty: no RAS change, ras_count stays 0.
REQ-034 Push and pop same fire, not empty: pc_out <= old top, top entry replaced by ras_push_addr, ras_count unchanged.
REQ-035 Push and pop same fire, empty: treated as push only; PC advances by 4.
REQ-036 trap_valid clears RAS (ras_count <= 0); redirect_valid leaves RAS unchanged; push/pop ignored in a trap or redirect cycle.
REQ-037 misalign_err = 0 in all cycles not covered by REQ-024.

Reset
REQ-038 rst low asynchronously forces pc_out = RESET_VECTOR, pc_valid = 0, misalign_err = 0, ras_count = 0, RAS pointer = 0.
REQ-039 rst asserted mid-operation (pending redirect, full RAS) discards all state.
REQ-040 RAS entry contents are not reset.
REQ-041 Release is synchronous to clk; first fire is possible no earlier than the second edge after release.

Verification
REQ-042 Reset release, if_ready = 1, no other inputs, 3 edges -> pc_valid 0 then 1; pc_out 0x0, 0x0, 0x4, 0x8.
REQ-043 stall = 1 with redirect_valid, redirect_pc = 0x200 -> pc_out = 0x200 next edge; 0x200 held while stall stays high.
REQ-044 trap_valid and redirect_valid (0x300) same cycle -> pc_out = 0x100, ras_count = 0; redirect_pc = 0x302 alone -> pc_out = 0x100, misalign_err pulses one cycle.
REQ-045 RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> count saturates at 4; 4 pops -> pc_out 0x50, 0x40, 0x30, 0x20; 5th pop -> pc_out = previous + 4, count 0.
REQ-046 RAS holds [0x10, 0x20]: push 0x99 and pop same fire -> pc_out = 0x20, count 2, next pop -> 0x99.
REQ-047 pc_out = 0xFFFF_FFFC, fire -> pc_out = 0x0; rst pulsed low mid-sequence -> immediate pc_out = 0x0, pc_valid = 0, ras_count = 0.

Source files
------------

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- instruction fetch program counter generator with return-address
// stack (RAS) prediction.
//
// Next-PC priority each rising edge: trap > redirect > RAS pop > sequential >
// hold. A misaligned redirect target diverts to TRAP_VECTOR and raises
// misalign_err for the following cycle.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   stall          in   pipeline hold (blocks sequential advance and RAS ops)
//   if_ready       in   instruction memory accepts pc_out
//   trap_valid     in   trap request
//   redirect_valid in   resolved branch/jump from execute
//   redirect_pc    in   redirect target
//   ras_push       in   call decoded, push ras_push_addr
//   ras_push_addr  in   return address of the call
//   ras_pop        in   return decoded, predict from RAS top
//   pc_out         out  current fetch PC (registered)
//   pc_valid       out  pc_out is a valid fetch request
//   misalign_err   out  one-cycle pulse after a misaligned redirect
//   ras_count      out  occupied RAS entries
//   ras_empty      out  ras_count == 0
// -----------------------------------------------------------------------------
module pc_gen #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
   parameter int                RAS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           if_ready,
   input  logic                           trap_valid,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   input  logic                           ras_push,
   input  logic [XLEN-1:0]                ras_push_addr,
   input  logic                           ras_pop,
   output logic [XLEN-1:0]                pc_out,
   output logic                           pc_valid,
   output logic                           misalign_err,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_empty
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q;
   logic            misalign_q, misalign_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   top_q, top_d;

   // RAS storage: contents are deliberately not reset, only the pointer/count.
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic            wr_en;
   logic [PW-1:0]   wr_idx;

   logic fire;
   logic empty;

   assign fire  = pc_valid_q & if_ready & ~stall & ~trap_valid & ~redirect_valid;
   assign empty = (cnt_q == '0);

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      cnt_d      = cnt_q;
      top_d      = top_q;
      wr_en      = 1'b0;
      wr_idx     = top_q;

      if (trap_valid) begin
         pc_d  = TRAP_VECTOR;
         cnt_d = '0;
      end else if (redirect_valid) begin
         if (redirect_pc[1:0] != 2'b00) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
         end else begin
            pc_d = redirect_pc;
         end
      end else if (fire) begin
         if (ras_pop && !empty) begin
            pc_d = ras_mem[top_q];
            if (ras_push) begin
               // Call and return together: the popped slot is reused in place.
               wr_en  = 1'b1;
               wr_idx = top_q;
            end else begin
               top_d = top_q - 1'b1;
               cnt_d = cnt_q - 1'b1;
            end
         end else begin
            // Sequential fetch; a pop on an empty stack falls through here.
            pc_d = pc_q + XLEN'(4);
            if (ras_push) begin
               // When full, top+1 wraps onto the oldest entry and overwrites it.
               wr_en  = 1'b1;
               wr_idx = top_q + 1'b1;
               top_d  = top_q + 1'b1;
               if (cnt_q != DEPTH_C) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
         top_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= 1'b1;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
         top_q      <= top_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         ras_mem[wr_idx] <= ras_push_addr;
      end
   end

   assign pc_out       = pc_q;
   assign pc_valid     = pc_valid_q;
   assign misalign_err = misalign_q;
   assign ras_count    = cnt_q;
   assign ras_empty    = empty;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        if_ready;
   logic        trap_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ras_push;
   logic [31:0] ras_push_addr;
   logic        ras_pop;
   logic [31:0] pc_out;
   logic        pc_valid;
   logic        misalign_err;
   logic [2:0]  ras_count;
   logic        ras_empty;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .if_ready       (if_ready),
      .trap_valid     (trap_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ras_push       (ras_push),
      .ras_push_addr  (ras_push_addr),
      .ras_pop        (ras_pop),
      .pc_out         (pc_out),
      .pc_valid       (pc_valid),
      .misalign_err   (misalign_err),
      .ras_count      (ras_count),
      .ras_empty      (ras_empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One rising edge; outputs are then sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_pc_cnt(input string tag, input logic [31:0] pc_e, input logic [31:0] cnt_e);
      chk({tag, "_pc"}, pc_out, pc_e);
      chk({tag, "_cnt"}, 32'(ras_count), cnt_e);
      $display("step %s: pc_out=%h ras_count=%0d misalign=%0b", tag, pc_out, ras_count, misalign_err);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; if_ready = 1'b1; trap_valid = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; ras_push = 1'b0;
      ras_push_addr = '0; ras_pop = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_valid", 32'(pc_valid), 32'd0);
      chk("rst_cnt", 32'(ras_count), 32'd0);
      chk("rst_empty", 32'(ras_empty), 32'd1);
      chk("rst_mis", 32'(misalign_err), 32'd0);

      // Release: pc_valid rises on first edge, PC advances from the second
      rst = 1'b1;
      tick();
      chk("rel1_valid", 32'(pc_valid), 32'd1);
      chk_pc_cnt("rel1", 32'h0, 0);
      tick(); chk_pc_cnt("rel2", 32'h4, 0);
      tick(); chk_pc_cnt("rel3", 32'h8, 0);

      // Redirect overrides stall; PC then holds while stalled
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick(); chk_pc_cnt("redir_stall", 32'h200, 0);
      redirect_valid = 1'b0;
      tick(); chk_pc_cnt("hold1", 32'h200, 0);
      tick(); chk_pc_cnt("hold2", 32'h200, 0);
      stall = 1'b0;

      // Trap beats redirect and clears the RAS
      ras_push = 1'b1; ras_push_addr = 32'h10;
      tick(); chk_pc_cnt("push_pre_trap", 32'h204, 1);
      ras_push = 1'b0; trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick(); chk_pc_cnt("trap", 32'h100, 0);
      chk("trap_mis", 32'(misalign_err), 32'd0);
      trap_valid = 1'b0; redirect_pc = 32'h302;
      tick(); chk_pc_cnt("misalign", 32'h100, 0);
      chk("misalign_pulse", 32'(misalign_err), 32'd1);
      redirect_valid = 1'b0;
      tick(); chk_pc_cnt("after_mis", 32'h104, 0);
      chk("misalign_end", 32'(misalign_err), 32'd0);

      // Fill RAS past its depth
      ras_push = 1'b1;
      ras_push_addr = 32'h10; tick(); chk_pc_cnt("push10", 32'h108, 1);
      ras_push_addr = 32'h20; tick(); chk_pc_cnt("push20", 32'h10C, 2);
      ras_push_addr = 32'h30; tick(); chk_pc_cnt("push30", 32'h110, 3);
      ras_push_addr = 32'h40; tick(); chk_pc_cnt("push40", 32'h114, 4);
      ras_push_addr = 32'h50; tick(); chk_pc_cnt("push50", 32'h118, 4);
      ras_push = 1'b0;

      // Pop in LIFO order, oldest (0x10) was overwritten
      ras_pop = 1'b1;
      tick(); chk_pc_cnt("pop1", 32'h50, 3);
      tick(); chk_pc_cnt("pop2", 32'h40, 2);
      tick(); chk_pc_cnt("pop3", 32'h30, 1);
      tick(); chk_pc_cnt("pop4", 32'h20, 0);
      tick(); chk_pc_cnt("pop_empty", 32'h24, 0);
      chk("pop_empty_flag", 32'(ras_empty), 32'd1);

      // Empty push+pop acts as a push only
      ras_push = 1'b1; ras_push_addr = 32'h10;
      tick(); chk_pc_cnt("pp_empty", 32'h28, 1);
      ras_pop = 1'b0; ras_push_addr = 32'h20;
      tick(); chk_pc_cnt("push20b", 32'h2C, 2);
      // Simultaneous push+pop on a non-empty stack replaces the top
      ras_pop = 1'b1; ras_push_addr = 32'h99;
      tick(); chk_pc_cnt("pp_full", 32'h20, 2);
      ras_push = 1'b0;
      tick(); chk_pc_cnt("pop99", 32'h99, 1);
      tick(); chk_pc_cnt("pop10", 32'h10, 0);
      ras_pop = 1'b0;

      // Stall without redirect holds the PC
      stall = 1'b1;
      tick(); chk_pc_cnt("stall_hold", 32'h10, 0);
      stall = 1'b0;

      // Address wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick(); chk_pc_cnt("to_top", 32'hFFFF_FFFC, 0);
      redirect_valid = 1'b0;
      tick(); chk_pc_cnt("wrap", 32'h0, 0);
      ras_push = 1'b1; ras_push_addr = 32'hAA;
      tick(); chk_pc_cnt("push_aa", 32'h4, 1);
      ras_push = 1'b0; if_ready = 1'b0;
      tick(); chk_pc_cnt("not_ready", 32'h4, 1);
      if_ready = 1'b1;

      // Asynchronous reset mid-cycle
      redirect_valid = 1'b1; redirect_pc = 32'h400;
      #2 rst = 1'b0;
      #1;
      chk_pc_cnt("async_rst", 32'h0, 0);
      chk("async_rst_valid", 32'(pc_valid), 32'd0);
      redirect_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick(); chk_pc_cnt("rel_again", 32'h0, 0);
      tick(); chk_pc_cnt("rel_again2", 32'h4, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
